// File: rtl/taylor_rr_scheduler.sv
// Round-robin front end that shares one Taylor cosine core among N requesters.
// Handles the core start/ready handshake, tags each result with its requester, and aborts hung operations with a watchdog.
module taylor_rr_scheduler #(
  parameter int N       = 4,
  parameter int W       = 24,
  parameter int TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       angle_in,
  output logic [N-1:0]         res_valid,
  output logic [W-1:0]         res_data,
  output logic [$clog2(N)-1:0] res_id,
  output logic                 res_err,
  output logic                 busy,
  output logic                 err_sticky,
  output logic                 core_reset,
  output logic                 core_start,
  output logic [W-1:0]         core_angle,
  input  logic                 core_ready,
  input  logic [W-1:0]         core_result
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cur_id;
  logic [CW-1:0]   wd;
  logic [1:0]      rst_sync;
  logic            grant_found;
  logic [IW-1:0]   grant_id;
  logic            grant;
  logic            capture;
  logic            abort;
  logic            wd_expired;

  // Reset asserts immediately; release (and the post-abort pulse) shifts out through two flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= abort ? 2'b11 : {rst_sync[0], 1'b0};
  end

  assign core_reset = rst_sync[1];

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[IW'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  assign wd_expired = (wd == CW'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found && !core_reset) begin
          grant      = 1'b1;
          next_state = S_START;
        end
      end
      S_START: begin
        // A stale ready from the previous result means the core has not accepted yet.
        if (wd_expired) begin
          abort      = 1'b1;
          next_state = S_DONE;
        end else if (!core_ready) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_ready) begin
          capture    = 1'b1;
          next_state = S_DONE;
        end else if (wd_expired) begin
          abort      = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cur_id     <= '0;
      wd         <= '0;
      core_angle <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state <= next_state;
      if (grant) begin
        cur_id     <= grant_id;
        core_angle <= angle_in[grant_id*W +: W];
        res_err    <= 1'b0;
        wd         <= '0;
      end else if (state == S_START || state == S_WAIT) begin
        wd <= wd + 1'b1;
      end
      if (capture) res_data <= core_result;
      if (abort) begin
        res_data   <= '0;
        res_err    <= 1'b1;
        err_sticky <= 1'b1;
      end
      if (state == S_DONE) ptr <= (cur_id == IW'(N - 1)) ? '0 : cur_id + 1'b1;
    end
  end

  assign core_start = (state == S_START);
  assign busy       = (state != S_IDLE);
  assign res_id     = cur_id;
  assign res_valid  = (state == S_DONE) ? ({{(N-1){1'b0}}, 1'b1} << cur_id) : '0;

endmodule
